// File: rtl/audio_pll_supervisor_pkg.sv
// Shared types and sizing helpers for the audio PLL supervisor.
package audio_pll_supervisor_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } sup_state_e;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/audio_pll_supervisor_sync2.sv
// Two-flop synchronizer for asynchronous status bits; also used for other audio-path flags.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/audio_pll_supervisor.sv
// Audio PLL supervisor: pulses the PLL reset, qualifies lock, gates the audio reset request,
// retries or faults on lock timeout and counts lock losses. Runs only on the reference clock.
module audio_pll_supervisor
    import audio_pll_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 5000,
    parameter int RETRY_MAX           = 3,
    parameter int CNT_W               = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             clr_cnt,
    output logic             pll_rst,
    output logic             audio_rst_req,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int TMR_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));
    localparam int RET_W = cnt_width(RETRY_MAX);

    sup_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] stable_q, stable_d;
    logic [RET_W-1:0] retry_q, retry_d;
    logic             lock_s;
    logic             loss;

    sync2 u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PLL_RST;
            timer_q  <= '0;
            stable_q <= '0;
            retry_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            stable_q <= stable_d;
            retry_q  <= retry_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        retry_d  = retry_q;
        loss     = 1'b0;
        case (state_q)
            PLL_RST: begin
                if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d  = STABLE;
                    stable_d = '0;
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    timer_d = '0;
                    if (retry_q == RET_W'(RETRY_MAX - 1)) begin
                        state_d = FAULT;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + RET_W'(1);
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            STABLE: begin
                // A lock dropout here restarts qualification without consuming a retry.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (stable_q == TMR_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end else begin
                    stable_d = stable_q + TMR_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                    loss    = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PLL_RST;
                timer_d = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the transition.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst       <= 1'b1;
            audio_rst_req <= 1'b1;
            ready         <= 1'b0;
            fault         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            pll_rst       <= (state_d == PLL_RST);
            audio_rst_req <= (state_d != RUN);
            ready         <= (state_d == RUN);
            fault         <= (state_d == FAULT);
            if (clr_cnt) begin
                lock_loss_cnt <= loss ? CNT_W'(1) : '0;
            end else if (loss && (lock_loss_cnt != {CNT_W{1'b1}})) begin
                lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_audio_pll_supervisor.sv
// Scoreboard bench: a phase-level reference model predicts every output change; a monitor checks them.
module tb_audio_pll_supervisor;

    localparam int P    = 4;
    localparam int T    = 32;
    localparam int N    = 8;
    localparam int R    = 2;
    localparam int CW   = 8;
    localparam int MAXN = 6000;

    localparam bit [3:0]  F_PULSE = 4'b1100;
    localparam bit [3:0]  F_HOLD  = 4'b0100;
    localparam bit [3:0]  F_RUN   = 4'b0010;
    localparam bit [3:0]  F_FAULT = 4'b0101;
    localparam bit [11:0] RST_VEC = {F_PULSE, 8'h00};

    logic          refclk     = 1'b0;
    logic          rst_n      = 1'b1;
    logic          pll_locked = 1'b0;
    logic          clr_cnt    = 1'b0;
    logic          pll_rst;
    logic          audio_rst_req;
    logic          ready;
    logic          fault;
    logic [CW-1:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc;
    bit mon_en   = 1'b0;
    logic [11:0] prev = RST_VEC;

    bit       lk [MAXN+1];
    bit       cl [MAXN+1];
    bit [3:0] ef [MAXN+1];
    bit       ls [MAXN+1];

    typedef struct {
        int          k;
        logic [11:0] v;
    } ev_t;
    ev_t sbq[$];

    audio_pll_supervisor #(
        .PLL_RST_CYCLES      (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (N),
        .RETRY_MAX           (R),
        .CNT_W               (CW)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .clr_cnt       (clr_cnt),
        .pll_rst       (pll_rst),
        .audio_rst_req (audio_rst_req),
        .ready         (ready),
        .fault         (fault),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    always @(posedge refclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: every observed change of the output vector must match the next predicted event.
    always @(negedge refclk) begin
        logic [11:0] now;
        ev_t e;
        now = {pll_rst, audio_rst_req, ready, fault, lock_loss_cnt};
        if (mon_en) begin
            if (!rst_n) begin
                prev = RST_VEC;
            end else if (now !== prev) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cycle=%0d got=%h expected no change", cyc, now);
                end else begin
                    e = sbq.pop_front();
                    if (e.k != cyc || e.v !== now) begin
                        failures++;
                        $display("FAIL output_event cycle=%0d got=%h expected cycle=%0d value=%h",
                                 cyc, now, e.k, e.v);
                    end
                end
                prev = now;
            end
        end
    end

    // lock as seen by the supervisor's decision at edge k (two-flop synchronizer lag)
    function automatic bit lock_seen(input int k, input int n);
        if (k < 3 || k - 2 > n) return 1'b0;
        return lk[k-2];
    endfunction

    function automatic int first_level(input int a, input int b, input bit lvl, input int n);
        for (int k = a; k <= b; k++)
            if (lock_seen(k, n) == lvl) return k;
        return 0;
    endfunction

    task automatic fill(input int a, input int b, input bit [3:0] v, input int n);
        for (int k = a; k <= b && k <= n; k++) ef[k] = v;
    endtask

    // Walks the supervision phases by scanning the lock history, jumping phase to phase.
    task automatic model_phases(input int n);
        int t, retry, ph, hit;
        for (int k = 0; k <= n; k++) ls[k] = 1'b0;
        t = 0; retry = 0; ph = 0;
        while (t <= n) begin
            case (ph)
                0: begin
                    fill(t, t + P - 1, F_PULSE, n);
                    t += P; ph = 1;
                end
                1: begin
                    hit = first_level(t + 1, t + T, 1'b1, n);
                    if (hit > 0) begin
                        fill(t, hit - 1, F_HOLD, n);
                        t = hit; ph = 2;
                    end else begin
                        fill(t, t + T - 1, F_HOLD, n);
                        t += T;
                        if (retry == R - 1) ph = 4;
                        else begin retry++; ph = 0; end
                    end
                end
                2: begin
                    hit = first_level(t + 1, t + N, 1'b0, n);
                    if (hit > 0) begin
                        fill(t, hit - 1, F_HOLD, n);
                        t = hit; ph = 1;
                    end else begin
                        fill(t, t + N - 1, F_HOLD, n);
                        t += N; retry = 0; ph = 3;
                    end
                end
                3: begin
                    hit = first_level(t + 1, n, 1'b0, n);
                    if (hit > 0) begin
                        fill(t, hit - 1, F_RUN, n);
                        ls[hit] = 1'b1;
                        t = hit; ph = 0;
                    end else begin
                        fill(t, n, F_RUN, n);
                        t = n + 1;
                    end
                end
                default: begin
                    fill(t, n, F_FAULT, n);
                    t = n + 1;
                end
            endcase
        end
    endtask

    task automatic model_emit(input int n);
        int c;
        logic [11:0] v, pv;
        ev_t e;
        c = 0; pv = RST_VEC;
        for (int k = 1; k <= n; k++) begin
            if (cl[k])                 c = ls[k] ? 1 : 0;
            else if (ls[k] && c < 255) c++;
            v = {ef[k], 8'(c)};
            if (v != pv) begin
                e.k = k; e.v = v;
                sbq.push_back(e);
            end
            pv = v;
        end
    endtask

    task automatic set_lock(input int a, input int b, input bit v);
        for (int k = a; k <= b; k++) begin lk[k] = v; cl[k] = 1'b0; end
    endtask

    task automatic gen_random(input int n);
        bit v;
        int len, k;
        v = 1'($urandom_range(0, 1)); k = 1;
        while (k <= n) begin
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 3);
                1:       len = $urandom_range(4, 12);
                2:       len = $urandom_range(13, 40);
                default: len = $urandom_range(41, 90);
            endcase
            for (int j = 0; j < len && k <= n; j++) begin
                lk[k] = v;
                cl[k] = ($urandom_range(0, 29) == 0);
                k++;
            end
            v = ~v;
        end
    endtask

    task automatic do_reset();
        @(posedge refclk); #2;
        rst_n = 1'b0; pll_locked = 1'b0; clr_cnt = 1'b0;
        #1;
        mon_en = 1'b1;
        checks++;
        if ({pll_rst, audio_rst_req, ready, fault, lock_loss_cnt} !== RST_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h expected=%h",
                     {pll_rst, audio_rst_req, ready, fault, lock_loss_cnt}, RST_VEC);
        end
        @(posedge refclk); #2;
        rst_n = 1'b1;
    endtask

    task automatic run_seg(input int n);
        do_reset();
        for (int k = 1; k <= n; k++) begin
            pll_locked = lk[k];
            clr_cnt    = cl[k];
            @(posedge refclk); #2;
        end
        pll_locked = 1'b0; clr_cnt = 1'b0;
        @(negedge refclk); #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL missing_events pending=%0d expected 0 next_cycle=%0d next_value=%h",
                     sbq.size(), sbq[0].k, sbq[0].v);
        end
        sbq.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last;

        // first lock, then a loss in RUN and a relock
        set_lock(1, 13, 1'b0); set_lock(14, 60, 1'b1); set_lock(61, 63, 1'b0); set_lock(64, 120, 1'b1);
        model_phases(120); model_emit(120); run_seg(120);

        // single-cycle dropout while qualifying lock
        set_lock(1, 13, 1'b0); set_lock(14, 19, 1'b1); set_lock(20, 20, 1'b0); set_lock(21, 80, 1'b1);
        model_phases(80); model_emit(80); run_seg(80);

        // never locks: retries, then a sticky fault that ignores a late lock
        set_lock(1, 100, 1'b0); set_lock(101, 140, 1'b1);
        model_phases(140); model_emit(140); run_seg(140);

        // repeated losses drive the counter into saturation, then clear tests
        n = 280 * 19 + 60;
        for (int k = 1; k <= n; k++) begin
            lk[k] = (k > 280 * 19) || (((k - 1) % 19) < 16);
            cl[k] = 1'b0;
        end
        model_phases(n);
        last = 0;
        for (int k = 1; k <= n; k++) if (ls[k]) last = k;
        if (last > 0) begin
            cl[last] = 1'b1;
            if (last + 30 <= n) cl[last + 30] = 1'b1;
        end
        model_emit(n); run_seg(n);

        for (int s = 0; s < 6; s++) begin
            gen_random(400);
            model_phases(400); model_emit(400); run_seg(400);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
